// File: rtl/vga_driver_pkg.sv
// Shared VGA timing parameters (1024x768 @ 60 Hz) and the phase state type
// used by both the horizontal and vertical timing generators.
package vga_driver_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_SYNC   = 136;
  localparam int H_BACK   = 160;
  localparam int H_ACTIVE = 1024;
  localparam int H_FRONT  = 24;
  localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

  // Vertical timing, in lines
  localparam int V_SYNC   = 6;
  localparam int V_BACK   = 29;
  localparam int V_ACTIVE = 768;
  localparam int V_FRONT  = 3;
  localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // First active pixel / first active line
  localparam int HA0 = H_SYNC + H_BACK;
  localparam int VA0 = V_SYNC + V_BACK;

  // Counter and pixel widths
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;
  localparam int RGB_W   = 24;

  // Colour constants
  localparam logic [RGB_W-1:0] COLOR_BLACK = 24'h000000;

  // Phase of one timing axis; the same encoding serves H and V
  typedef enum logic [1:0] {
    SYNC_S  = 2'd0,
    BACK_S  = 2'd1,
    ACT_S   = 2'd2,
    FRONT_S = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_driver_phase_fsm.sv
// vga_phase_fsm: one timing axis. A position counter that runs 0..TOTAL-1
// when i_adv is high and wraps to 0, plus a 4-state phase FSM
// (sync -> back porch -> active -> front porch) kept in step with it.
// The phase register always describes the current counter value.
module vga_phase_fsm
  import vga_driver_pkg::*;
#(
  parameter int SYNC   = H_SYNC,
  parameter int BACK   = H_BACK,
  parameter int ACTIVE = H_ACTIVE,
  parameter int FRONT  = H_FRONT,
  parameter int W      = H_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_adv,
  output logic [W-1:0] o_cnt,
  output phase_t       o_phase
);

  localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;

  // Counter values at which each phase begins, and the wrap point
  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] BACK0  = W'(SYNC);
  localparam logic [W-1:0] ACT0   = W'(SYNC + BACK);
  localparam logic [W-1:0] FRONT0 = W'(SYNC + BACK + ACTIVE);

  logic [W-1:0] r_cnt;
  phase_t       r_phase;
  logic [W-1:0] w_nxt;

  assign w_nxt   = r_cnt + W'(1);
  assign o_cnt   = r_cnt;
  assign o_phase = r_phase;

  // Counter and phase advance together; phase changes on the edge the
  // counter reaches a phase boundary, and wrap returns to the sync phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= SYNC_S;
    end else if (i_adv) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_phase <= SYNC_S;
      end else begin
        r_cnt <= w_nxt;
        if (w_nxt == BACK0)       r_phase <= BACK_S;
        else if (w_nxt == ACT0)   r_phase <= ACT_S;
        else if (w_nxt == FRONT0) r_phase <= FRONT_S;
      end
    end
  end

endmodule

// File: rtl/vga_driver.sv
// vga_driver: VGA timing generator and pixel path.
// Two vga_phase_fsm instances track the line (h) and frame (v) position.
// rd_req is issued combinationally one clock ahead of display enable so the
// upstream pixel arrives just in time to be registered alongside vga_de.
// Build option: define SYNC_ACTIVE_LOW_EN to make vga_hs/vga_vs active-low
// (default is active-high sync pulses).
// Timing parameters default to the shared package values; overriding them
// only scales the raster.
module vga_driver
  import vga_driver_pkg::*;
#(
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BACK   = H_BACK,
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FRONT  = H_FRONT,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BACK   = V_BACK,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FRONT  = V_FRONT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] rgb_din,
  output logic             rd_req,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb
);

`ifdef SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  localparam int P_H_TOTAL = P_H_SYNC + P_H_BACK + P_H_ACTIVE + P_H_FRONT;
  localparam int P_HA0     = P_H_SYNC + P_H_BACK;

  // Request window: one clock ahead of the active pixel window
  localparam logic [H_CNT_W-1:0] H_LAST    = H_CNT_W'(P_H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_REQ_FST = H_CNT_W'(P_HA0 - 1);
  localparam logic [H_CNT_W-1:0] H_REQ_LST = H_CNT_W'(P_HA0 + P_H_ACTIVE - 2);

  logic [H_CNT_W-1:0] w_h_cnt;
  logic [V_CNT_W-1:0] w_v_cnt;
  phase_t             w_h_phase;
  phase_t             w_v_phase;
  logic               w_h_wrap;
  logic               w_de;
  logic               w_v_act;

  vga_phase_fsm #(
    .SYNC   (P_H_SYNC),
    .BACK   (P_H_BACK),
    .ACTIVE (P_H_ACTIVE),
    .FRONT  (P_H_FRONT),
    .W      (H_CNT_W)
  ) u_h_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (1'b1),
    .o_cnt   (w_h_cnt),
    .o_phase (w_h_phase)
  );

  // Lines advance on the h wrap edge, so both counters wrap together at
  // the last pixel of the last line.
  assign w_h_wrap = (w_h_cnt == H_LAST);

  vga_phase_fsm #(
    .SYNC   (P_V_SYNC),
    .BACK   (P_V_BACK),
    .ACTIVE (P_V_ACTIVE),
    .FRONT  (P_V_FRONT),
    .W      (V_CNT_W)
  ) u_v_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (w_h_wrap),
    .o_cnt   (w_v_cnt),
    .o_phase (w_v_phase)
  );

  assign w_v_act = (w_v_phase == ACT_S);
  assign w_de    = (w_h_phase == ACT_S) && w_v_act;

  // Pixel request leads display enable by one clock within active lines
  always_comb begin
    rd_req = 1'b0;
    if (w_v_act && (w_h_cnt >= H_REQ_FST) && (w_h_cnt <= H_REQ_LST))
      rd_req = 1'b1;
  end

  // Registered video outputs, one clock behind the counters; the pixel
  // answering last cycle's rd_req lands together with vga_de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs  <= ~SYNC_ON;
      vga_vs  <= ~SYNC_ON;
      vga_de  <= 1'b0;
      vga_rgb <= COLOR_BLACK;
    end else begin
      vga_hs  <= (w_h_phase == SYNC_S) ? SYNC_ON : ~SYNC_ON;
      vga_vs  <= (w_v_phase == SYNC_S) ? SYNC_ON : ~SYNC_ON;
      vga_de  <= w_de;
      vga_rgb <= w_de ? rgb_din : COLOR_BLACK;
    end
  end

  // The v counter value itself is only needed for debug visibility of the
  // frame position; phases carry all decisions.
  logic [V_CNT_W-1:0] r_v_cnt_dbg;

  // Keep the last line index seen at the start of each line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_v_cnt_dbg <= '0;
    else if (w_h_wrap) r_v_cnt_dbg <= w_v_cnt;
  end

endmodule

// File: tb/tb_vga_driver.sv
// Bench for vga_driver on a scaled raster (H 4/3/8/2 = 17, V 2/2/4/1 = 9,
// frame = 153 clks). A source answers every rd_req with an incrementing
// index and queues it; a monitor pops the queue whenever vga_de is high.
// A position tracker checks timing of rd_req/hs/vs/de every clock.
module tb_vga_driver;

  localparam int HT = 17;
  localparam int VT = 9;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] FILL = 24'hA5A5A5;

`ifdef SYNC_ACTIVE_LOW_EN
  localparam logic ON = 1'b0;
`else
  localparam logic ON = 1'b1;
`endif

  logic        clk;
  logic        rst_n;
  logic [23:0] rgb_din;
  logic        rd_req;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [23:0] vga_rgb;

  int checks   = 0;
  int failures = 0;

  vga_driver #(
    .P_H_SYNC(4), .P_H_BACK(3), .P_H_ACTIVE(8), .P_H_FRONT(2),
    .P_V_SYNC(2), .P_V_BACK(2), .P_V_ACTIVE(4), .P_V_FRONT(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rgb_din (rgb_din),
    .rd_req  (rd_req),
    .vga_hs  (vga_hs),
    .vga_vs  (vga_vs),
    .vga_de  (vga_de),
    .vga_rgb (vga_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: monitor pops first, then source answers last cycle's request
  logic [23:0] exp_q[$];
  logic [23:0] pix = 24'd0;
  logic        prev_req = 1'b0;
  initial rgb_din = FILL;

  always @(negedge clk) begin
    if (vga_de) begin
      if (exp_q.size() == 0) chk("rgb_underflow", 32'd0, 32'd1);
      else chk("rgb_pixel", {8'h0, vga_rgb}, {8'h0, exp_q.pop_front()});
    end else begin
      chk("rgb_blank", {8'h0, vga_rgb}, 32'd0);
    end
    if (!rst_n) begin
      prev_req = 1'b0;
      exp_q.delete();
      rgb_din = FILL;
    end else begin
      if (prev_req) begin
        rgb_din = pix;
        exp_q.push_back(pix);
        pix = pix + 24'd1;
      end else begin
        rgb_din = FILL;
      end
      prev_req = rd_req;
    end
  end

  // Position tracker: sample k sees counters at position k and registered
  // outputs for position k-1 (k = 1 is the first negedge after release).
  int k = 0;
  int rd_sum = 0, hs_sum = 0, vs_sum = 0, de_sum = 0;
  always @(negedge clk) begin
    int h, v, hp, vp;
    if (!rst_n) begin
      k = 0; rd_sum = 0; hs_sum = 0; vs_sum = 0; de_sum = 0;
    end else begin
      k++;
      h  = k % HT;       v  = (k / HT) % VT;
      hp = (k - 1) % HT; vp = ((k - 1) / HT) % VT;
      chk("rd_req_t", {31'd0, rd_req}, {31'd0, (h >= 6 && h <= 13 && v >= 4 && v <= 7)});
      chk("hs_t", {31'd0, vga_hs}, {31'd0, (hp < 4) ? ON : ~ON});
      chk("vs_t", {31'd0, vga_vs}, {31'd0, (vp < 2) ? ON : ~ON});
      chk("de_t", {31'd0, vga_de}, {31'd0, (hp >= 7 && hp <= 14 && vp >= 4 && vp <= 7)});
      rd_sum += int'(rd_req);
      hs_sum += int'(vga_hs == ON);
      vs_sum += int'(vga_vs == ON);
      de_sum += int'(vga_de);
      if (k % FRAME == 0) begin
        chk("frame_rd_req", rd_sum, 32'd32);
        chk("frame_hs", hs_sum, 32'd36);
        chk("frame_vs", vs_sum, 32'd34);
        chk("frame_de", de_sum, 32'd32);
        rd_sum = 0; hs_sum = 0; vs_sum = 0; de_sum = 0;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"}, {31'd0, vga_hs}, {31'd0, ~ON});
    chk({tag, "_vs"}, {31'd0, vga_vs}, {31'd0, ~ON});
    chk({tag, "_de"}, {31'd0, vga_de}, 32'd0);
    chk({tag, "_rgb"}, {8'h0, vga_rgb}, 32'd0);
    chk({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("hs_first", {31'd0, vga_hs}, {31'd0, ON});
    // Run to frame 3, line 5, pixel 9 (active region), then reset mid-frame
    repeat (399) @(negedge clk);
    chk("pre_rst_de", {31'd0, vga_de}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    // First request after release: line 4, h 6 -> sample 4*17+6
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_req && n < 200);
    chk("restart_rd_req_seen", {31'd0, rd_req}, 32'd1);
    chk("restart_rd_req_pos", n, 32'd74);
    repeat (FRAME + 10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
